// File: rtl/code_lock_ctrl.sv
// Keypad lock FSM: digit entry/edit, key compare, error hold, alarm lockout, auto-relock, key change.
// Latency: every input pulse is reflected on the registered outputs one cycle after it is sampled.
// Backpressure: none; inputs are single-cycle event pulses, and events that are not honoured are dropped.
module code_lock_ctrl #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int ERR_HOLD       = 4,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int UNLOCK_CYCLES  = 32,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_KEY = 16'h1234
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        DIGIT_VALID,
    input  logic [DIGIT_W-1:0]          DIGIT_VAL,
    input  logic                        BTN_OK,
    input  logic                        BTN_BACK,
    input  logic                        BTN_ADMIN,
    input  logic                        BTN_CLEAR,
    output logic [2:0]                  STATE,
    output logic [DIGITS*DIGIT_W-1:0]   ENTRY,
    output logic [$clog2(DIGITS+1)-1:0] ENTRY_LEN,
    output logic [3:0]                  ERR_CNT,
    output logic                        UNLOCKED,
    output logic                        ALARM,
    output logic                        KEY_UPDATED
);

    localparam int EW    = DIGITS * DIGIT_W;
    localparam int LW    = $clog2(DIGITS + 1);
    localparam int TMAX0 = (ERR_HOLD > LOCKOUT_CYCLES) ? ERR_HOLD : LOCKOUT_CYCLES;
    localparam int TMAX  = (TMAX0 > UNLOCK_CYCLES) ? TMAX0 : UNLOCK_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_INPUT  = 3'd1;
    localparam logic [2:0] S_ERROR  = 3'd2;
    localparam logic [2:0] S_ALARM  = 3'd3;
    localparam logic [2:0] S_UNLOCK = 3'd4;
    localparam logic [2:0] S_SETKEY = 3'd5;

    logic [2:0]    state_q,    state_d;
    logic [EW-1:0] entry_q,    entry_d;
    logic [LW-1:0] len_q,      len_d;
    logic [3:0]    err_cnt_q,  err_cnt_d;
    logic [EW-1:0] key_q,      key_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic          key_upd_q,  key_upd_d;
    logic          unlocked_q, unlocked_d;
    logic          alarm_q,    alarm_d;

    logic          ev_clear, ev_ok, ev_back, ev_admin, ev_digit;
    logic          dig_acc, can_pop, len_full, full_match, timer_done;
    logic [EW-1:0] entry_push, entry_pop;
    logic [3:0]    err_inc;

    // Resolve simultaneous events into the single winning event and precompute datapath terms
    always_comb begin
        ev_clear   = BTN_CLEAR;
        ev_ok      = BTN_OK    & ~BTN_CLEAR;
        ev_back    = BTN_BACK  & ~BTN_OK & ~BTN_CLEAR;
        ev_admin   = BTN_ADMIN & ~BTN_BACK & ~BTN_OK & ~BTN_CLEAR;
        ev_digit   = DIGIT_VALID & ~BTN_ADMIN & ~BTN_BACK & ~BTN_OK & ~BTN_CLEAR;
        len_full   = (len_q == LW'(DIGITS));
        dig_acc    = ev_digit & ~len_full &
                     ({{(32-DIGIT_W){1'b0}}, DIGIT_VAL} <= 32'd9);
        can_pop    = ev_back & (len_q != '0);
        entry_push = (entry_q << DIGIT_W) | {{(EW-DIGIT_W){1'b0}}, DIGIT_VAL};
        entry_pop  = entry_q >> DIGIT_W;
        full_match = len_full & (entry_q == key_q);
        timer_done = (timer_q <= TW'(1));
        err_inc    = (err_cnt_q >= 4'(MAX_TRIES)) ? err_cnt_q : err_cnt_q + 4'd1;
    end

    // State and datapath registers, asynchronous reset to power-on values including the default key
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_WAIT;
            entry_q    <= '0;
            len_q      <= '0;
            err_cnt_q  <= '0;
            key_q      <= DEFAULT_KEY;
            timer_q    <= '0;
            key_upd_q  <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            len_q      <= len_d;
            err_cnt_q  <= err_cnt_d;
            key_q      <= key_d;
            timer_q    <= timer_d;
            key_upd_q  <= key_upd_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    // Next-state and datapath update; any transition to WAIT also empties the entry
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        len_d     = len_q;
        err_cnt_d = err_cnt_q;
        key_d     = key_q;
        timer_d   = timer_q;
        key_upd_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (dig_acc) begin
                    state_d = S_INPUT;
                    entry_d = entry_push;
                    len_d   = len_q + LW'(1);
                end
            end
            S_INPUT: begin
                if (ev_clear) begin
                    state_d = S_WAIT;
                    entry_d = '0;
                    len_d   = '0;
                end else if (ev_ok) begin
                    entry_d = '0;
                    len_d   = '0;
                    if (full_match) begin
                        state_d   = S_UNLOCK;
                        err_cnt_d = '0;
                        timer_d   = TW'(UNLOCK_CYCLES);
                    end else begin
                        err_cnt_d = err_inc;
                        if (err_inc == 4'(MAX_TRIES)) begin
                            state_d = S_ALARM;
                            timer_d = TW'(LOCKOUT_CYCLES);
                        end else begin
                            state_d = S_ERROR;
                            timer_d = TW'(ERR_HOLD);
                        end
                    end
                end else if (can_pop) begin
                    entry_d = entry_pop;
                    len_d   = len_q - LW'(1);
                end else if (dig_acc) begin
                    entry_d = entry_push;
                    len_d   = len_q + LW'(1);
                end
            end
            S_ERROR: begin
                if (ev_clear || timer_done) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_ALARM: begin
                // Lockout cannot be cut short by any button
                if (timer_done) begin
                    state_d   = S_WAIT;
                    err_cnt_d = '0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_UNLOCK: begin
                if (ev_clear) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else if (ev_admin) begin
                    state_d = S_SETKEY;
                    entry_d = '0;
                    len_d   = '0;
                    timer_d = '0;
                end else if (timer_done) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SETKEY: begin
                if (ev_clear) begin
                    state_d = S_WAIT;
                    entry_d = '0;
                    len_d   = '0;
                end else if (ev_ok) begin
                    entry_d = '0;
                    len_d   = '0;
                    if (len_full) begin
                        key_d     = entry_q;
                        key_upd_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end else if (can_pop) begin
                    entry_d = entry_pop;
                    len_d   = len_q - LW'(1);
                end else if (dig_acc) begin
                    entry_d = entry_push;
                    len_d   = len_q + LW'(1);
                end
            end
            default: begin
                state_d = S_WAIT;
                entry_d = '0;
                len_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    // Status flags follow the next state so they line up with STATE on the outputs
    always_comb begin
        unlocked_d = (state_d == S_UNLOCK);
        alarm_d    = (state_d == S_ALARM);
    end

    assign STATE       = state_q;
    assign ENTRY       = entry_q;
    assign ENTRY_LEN   = len_q;
    assign ERR_CNT     = err_cnt_q;
    assign UNLOCKED    = unlocked_q;
    assign ALARM       = alarm_q;
    assign KEY_UPDATED = key_upd_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with default parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_code_lock_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        DIGIT_VALID = 1'b0;
    logic [3:0]  DIGIT_VAL = 4'd0;
    logic        BTN_OK = 1'b0;
    logic        BTN_BACK = 1'b0;
    logic        BTN_ADMIN = 1'b0;
    logic        BTN_CLEAR = 1'b0;
    logic [2:0]  STATE;
    logic [15:0] ENTRY;
    logic [2:0]  ENTRY_LEN;
    logic [3:0]  ERR_CNT;
    logic        UNLOCKED;
    logic        ALARM;
    logic        KEY_UPDATED;

    int checks = 0;
    int errors = 0;

    code_lock_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .DIGIT_VALID(DIGIT_VALID), .DIGIT_VAL(DIGIT_VAL),
        .BTN_OK(BTN_OK), .BTN_BACK(BTN_BACK), .BTN_ADMIN(BTN_ADMIN), .BTN_CLEAR(BTN_CLEAR),
        .STATE(STATE), .ENTRY(ENTRY), .ENTRY_LEN(ENTRY_LEN), .ERR_CNT(ERR_CNT),
        .UNLOCKED(UNLOCKED), .ALARM(ALARM), .KEY_UPDATED(KEY_UPDATED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1ns after the edge that sampled them
    task automatic step(input logic dv, input logic [3:0] d, input logic ok,
                        input logic back, input logic admin, input logic clr);
        DIGIT_VALID = dv; DIGIT_VAL = d; BTN_OK = ok;
        BTN_BACK = back; BTN_ADMIN = admin; BTN_CLEAR = clr;
        @(posedge CLK); #1;
        DIGIT_VALID = 1'b0; DIGIT_VAL = 4'd0; BTN_OK = 1'b0;
        BTN_BACK = 1'b0; BTN_ADMIN = 1'b0; BTN_CLEAR = 1'b0;
    endtask

    task automatic dig(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ok_btn();    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic back_btn();  step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic admin_btn(); step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic clr_btn();   step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic code4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        dig(a); dig(b); dig(c); dig(d); ok_btn();
    endtask

    initial begin
        // Reset values
        idle(2);
        chk("rst_state", STATE, 0);
        chk("rst_entry", ENTRY, 0);
        chk("rst_len", ENTRY_LEN, 0);
        chk("rst_err", ERR_CNT, 0);
        chk("rst_flags", {UNLOCKED, ALARM, KEY_UPDATED}, 0);
        RESET_N = 1'b1;
        idle(1);

        // Correct code and auto-relock after 32 cycles
        dig(1); dig(2); dig(3); dig(4);
        chk("c_entry", ENTRY, 32'h1234);
        chk("c_len", ENTRY_LEN, 4);
        chk("c_state_in", STATE, 1);
        ok_btn();
        chk("c_unlock", STATE, 4);
        chk("c_unlocked", UNLOCKED, 1);
        chk("c_err", ERR_CNT, 0);
        chk("c_entry_clr", ENTRY, 0);
        idle(31);
        chk("c_still_unl", STATE, 4);
        idle(1);
        chk("c_relock", STATE, 0);
        chk("c_relock_flag", UNLOCKED, 0);

        // Lockout after three wrong codes
        code4(1, 2, 3, 5);
        chk("l1_state", STATE, 2);
        chk("l1_err", ERR_CNT, 1);
        idle(3);
        chk("l1_hold", STATE, 2);
        idle(1);
        chk("l1_wait", STATE, 0);
        code4(1, 2, 3, 5);
        chk("l2_state", STATE, 2);
        chk("l2_err", ERR_CNT, 2);
        idle(4);
        chk("l2_wait", STATE, 0);
        code4(1, 2, 3, 5);
        chk("l3_state", STATE, 3);
        chk("l3_alarm", ALARM, 1);
        chk("l3_err", ERR_CNT, 3);
        ok_btn();
        chk("l3_ok_ign", STATE, 3);
        clr_btn();
        chk("l3_clr_ign", STATE, 3);
        dig(7);
        chk("l3_dig_ign", {STATE, ENTRY_LEN}, {3'd3, 3'd0});
        idle(12);
        chk("l3_hold", ALARM, 1);
        idle(1);
        chk("l3_exit", STATE, 0);
        chk("l3_err_clr", ERR_CNT, 0);
        chk("l3_alarm_clr", ALARM, 0);

        // Edit limits
        dig(1); dig(2); back_btn(); back_btn(); back_btn();
        chk("e_len0", ENTRY_LEN, 0);
        chk("e_state", STATE, 1);
        chk("e_entry0", ENTRY, 0);
        dig(9); dig(8); dig(7); dig(6); dig(5);
        chk("e_full", ENTRY, 32'h9876);
        chk("e_len4", ENTRY_LEN, 4);
        back_btn();
        chk("e_back", ENTRY, 32'h987);
        dig(4'hA);
        chk("e_bad_dig", {ENTRY, 13'd0, ENTRY_LEN}, {16'h0987, 13'd0, 3'd3});
        clr_btn();
        chk("e_clear", {STATE, ENTRY_LEN}, {3'd0, 3'd0});

        // Simultaneous events
        dig(1); dig(2); dig(3);
        step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s_ok_dig_state", STATE, 2);
        chk("s_ok_dig_err", ERR_CNT, 1);
        chk("s_ok_dig_len", ENTRY_LEN, 0);
        idle(4);
        dig(1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("s_clr_ok_state", STATE, 0);
        chk("s_clr_ok_err", ERR_CNT, 1);
        admin_btn();
        chk("s_admin_wait", STATE, 0);
        dig(4'hB);
        chk("s_bad_wait", STATE, 0);

        // Key change
        code4(1, 2, 3, 4);
        chk("k_unlock", STATE, 4);
        chk("k_err_clr", ERR_CNT, 0);
        admin_btn();
        chk("k_setkey", STATE, 5);
        dig(5); dig(6); ok_btn();
        chk("k_short", {STATE, ENTRY_LEN}, {3'd5, 3'd0});
        dig(5); dig(6); dig(7); dig(8);
        chk("k_entry", ENTRY, 32'h5678);
        ok_btn();
        chk("k_upd", KEY_UPDATED, 1);
        chk("k_wait", STATE, 0);
        idle(1);
        chk("k_upd_pulse", KEY_UPDATED, 0);
        code4(1, 2, 3, 4);
        chk("k_old_fail", STATE, 2);
        idle(4);
        code4(5, 6, 7, 8);
        chk("k_new_ok", STATE, 4);
        chk("k_new_err", ERR_CNT, 0);
        clr_btn();
        chk("k_relock", STATE, 0);

        // Async reset mid-ALARM
        dig(9); ok_btn(); idle(4);
        dig(9); ok_btn(); idle(4);
        dig(9); ok_btn();
        chk("r_alarm", STATE, 3);
        idle(2);
        RESET_N = 1'b0;
        #2;
        chk("r_alarm_state", STATE, 0);
        chk("r_alarm_flags", {ALARM, ERR_CNT}, 0);
        idle(1);
        RESET_N = 1'b1;
        idle(1);
        code4(1, 2, 3, 4);
        chk("r_default_key", STATE, 4);

        // Async reset mid-SETKEY
        admin_btn();
        dig(7); dig(7);
        chk("r_setkey", {STATE, ENTRY_LEN}, {3'd5, 3'd2});
        RESET_N = 1'b0;
        #2;
        chk("r_sk_state", STATE, 0);
        chk("r_sk_entry", {ENTRY, 13'd0, ENTRY_LEN}, 0);
        idle(1);
        RESET_N = 1'b1;
        idle(1);
        code4(1, 2, 3, 4);
        chk("r_sk_unlock", {STATE, UNLOCKED}, {3'd4, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Parametrised successor of the switch/button password-lock controller. It takes pre-decoded, single-cycle digit and button event pulses from the SW/BTN front-end blocks and runs the lock state machine. Digit count, digit width, attempt limit and timers are all generics. Beyond the previous generation it adds: timed auto-relock, timed alarm lockout, a dedicated key-change mode reachable only while unlocked, and a defined priority for simultaneous events. It sits between the IO front-ends and the display/LED drivers.

Parameters:
DIGITS, 4, number of key digits (2..8)
DIGIT_W, 4, bits per digit
MAX_TRIES, 3, consecutive failed attempts that trigger ALARM (1..15)
ERR_HOLD, 4, cycles spent in ERROR before returning to WAIT
LOCKOUT_CYCLES, 16, ALARM duration in cycles
UNLOCK_CYCLES, 32, UNLOCK duration before auto-relock
DEFAULT_KEY, 16'h1234, key loaded at reset; width DIGITS*DIGIT_W

Ports:
CLK  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
DIGIT_VALID  in  1  one-cycle pulse: new digit present on DIGIT_VAL
DIGIT_VAL  in  DIGIT_W  digit value; only values 0..9 are accepted
BTN_OK  in  1  one-cycle pulse: submit entry
BTN_BACK  in  1  one-cycle pulse: delete last digit
BTN_ADMIN  in  1  one-cycle pulse: enter key-change mode (honoured in UNLOCK only)
BTN_CLEAR  in  1  one-cycle pulse: abort to WAIT
STATE  out  3  WAIT=0, INPUT=1, ERROR=2, ALARM=3, UNLOCK=4, SETKEY=5
ENTRY  out  DIGITS*DIGIT_W  current entry, right-aligned, first digit most significant
ENTRY_LEN  out  $clog2(DIGITS+1)  digits entered so far
ERR_CNT  out  4  consecutive failed attempts
UNLOCKED  out  1  high in UNLOCK
ALARM  out  1  high in ALARM
KEY_UPDATED  out  1  one-cycle pulse when a new key is stored

Behaviour:
- Reset (async assert, sync release): STATE=WAIT, ENTRY=0, ENTRY_LEN=0, ERR_CNT=0, KEY=DEFAULT_KEY, all flags 0, timers 0.
- All outputs are registered. The effect of an input pulse is visible on the cycle after it is sampled.
- Event priority within one cycle: CLEAR > OK > BACK > ADMIN > DIGIT. Only the highest-priority event acts; the others are dropped.
- Accepted digit: ENTRY <= {ENTRY << DIGIT_W} | DIGIT_VAL and ENTRY_LEN++.
  - Ignored when ENTRY_LEN==DIGITS.
  - Ignored when DIGIT_VAL>9.
- BACK: ENTRY >>= DIGIT_W and ENTRY_LEN--. No-op when ENTRY_LEN==0.
- WAIT:
  - Accepted digit -> INPUT, with the digit stored.
  - OK, BACK and ADMIN are ignored.
- INPUT:
  - OK with ENTRY_LEN==DIGITS and ENTRY==KEY -> UNLOCK; ERR_CNT=0.
  - OK otherwise (short entry or mismatch) -> ERR_CNT++. If the new count == MAX_TRIES -> ALARM, else -> ERROR.
  - Entry is cleared on every OK.
  - BACK to ENTRY_LEN==0 stays in INPUT.
  - CLEAR -> WAIT, entry cleared; ERR_CNT is kept.
- ERROR:
  - Holds ERR_HOLD cycles, then -> WAIT.
  - Digits, OK, BACK and ADMIN are ignored.
  - CLEAR -> WAIT immediately.
- ALARM:
  - Holds LOCKOUT_CYCLES cycles; all button and digit events, including CLEAR, are ignored.
  - On expiry -> WAIT with ERR_CNT=0. Only RESET_N exits early.
- UNLOCK:
  - Timer loads UNLOCK_CYCLES on entry. On expiry -> WAIT.
  - CLEAR -> WAIT (manual relock).
  - ADMIN -> SETKEY with entry cleared.
  - Digits, OK and BACK are ignored.
- SETKEY:
  - Digits and BACK edit ENTRY.
  - OK with ENTRY_LEN==DIGITS: KEY<=ENTRY, KEY_UPDATED pulses, -> WAIT.
  - OK with a short entry: entry cleared, stay in SETKEY, ERR_CNT unchanged.
  - CLEAR -> WAIT with KEY unchanged.
  - No timeout.
- Timers are down-counters of width $clog2(max+1). They load on state entry, and the state exits on the cycle the count reaches 1.
- ERR_CNT saturates at MAX_TRIES. It is cleared only by a successful unlock, ALARM expiry, or reset.
- Reset mid-operation: full return to reset values, including KEY=DEFAULT_KEY (no key retention across reset).
- Undefined STATE encodings -> WAIT on the next cycle.

Test Plan:
- Correct code: digits 1,2,3,4 then OK -> ENTRY=0x1234, LEN=4 before OK; then STATE=UNLOCK, UNLOCKED=1, ERR_CNT=0; STATE=WAIT after 32 cycles.
- Lockout: three attempts 1,2,3,5+OK -> ERR_CNT 1,2 with ERROR for 4 cycles each; third -> ALARM=1 for 16 cycles, OK and CLEAR pulses ignored; then WAIT, ERR_CNT=0.
- Edit limits: 1,2,BACK,BACK,BACK -> LEN=0, STATE=INPUT; then 9,8,7,6,5 -> ENTRY=0x9876, fifth digit dropped; DIGIT_VAL=0xA ignored.
- Simultaneous events: OK and DIGIT_VALID in the same cycle with 1,2,3 entered -> only OK acts: ERROR, ERR_CNT=1. CLEAR+OK in the same cycle -> WAIT, ERR_CNT unchanged.
- Key change: unlock, ADMIN, 5,6,7,8, OK -> KEY_UPDATED one cycle, WAIT; 1,2,3,4+OK fails; 5,6,7,8+OK unlocks. ADMIN pressed in WAIT is ignored.
- Async reset: drop RESET_N mid-ALARM and mid-SETKEY -> outputs at reset values immediately (same cycle, asynchronous); after release, 1,2,3,4+OK unlocks.
